// File: rtl/ws_frame_timer.sv
// Frame-level bit timer for WS2812-class LED strips.
// Walks slot (ns) / bit / pixel counters for a captured pixel count, then
// holds a latch gap of LATCH_SLOTS slots. A frame is requested with start.
// In continuous mode the next frame follows the latch gap with no idle cycle.
// abort cuts the data phase short and forces a full latch gap.
module ws_frame_timer #(
  parameter int unsigned PIXEL_W     = 8,
  parameter int unsigned BIT_W       = 5,
  parameter int unsigned NS_W        = 8,
  parameter int unsigned BITS        = 24,
  parameter int unsigned NSS         = 64,
  parameter int unsigned LATCH_SLOTS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [PIXEL_W-1:0] npix,
  output logic [PIXEL_W-1:0] pixel,
  output logic [BIT_W-1:0]   bit_idx,
  output logic [NS_W-1:0]    ns,
  output logic               bit_start,
  output logic               pixel_req,
  output logic               latch,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StLatch = 2'd2
  } state_e;

  localparam logic [NS_W-1:0]    NsLast    = NS_W'(NSS - 1);
  localparam logic [BIT_W-1:0]   BitLast   = BIT_W'(BITS - 1);
  localparam logic [BIT_W-1:0]   SlotLast  = BIT_W'(LATCH_SLOTS - 1);
  localparam logic [PIXEL_W-1:0] PixelOne  = PIXEL_W'(1);
  localparam logic [PIXEL_W-1:0] PixelZero = '0;

  state_e             state_q, state_d;
  logic [PIXEL_W-1:0] pixel_q, pixel_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NS_W-1:0]    ns_q, ns_d;
  logic [PIXEL_W-1:0] npix_q, npix_d;
  logic               frame_done_q, frame_done_d;

  // Slot / bit / pixel terminal conditions, shared by the next-state logic.
  logic slot_end;
  logic bit_end;
  logic pixel_end;
  logic latch_end;
  logic next_frame;
  state_e start_state;

  // Terminal-count decode.
  always_comb begin
    slot_end    = (ns_q == NsLast);
    bit_end     = slot_end && (bit_q == BitLast);
    // npix_q is never 0 while in data, so the subtraction cannot wrap there.
    pixel_end   = bit_end && (pixel_q == (npix_q - PixelOne));
    latch_end   = slot_end && (bit_q == SlotLast);
    next_frame  = continuous || start;
    // A zero pixel count skips the data phase entirely.
    start_state = (npix == PixelZero) ? StLatch : StData;
  end

  // Next-state and counter update.
  always_comb begin
    state_d      = state_q;
    pixel_d      = pixel_q;
    bit_d        = bit_q;
    ns_d         = ns_q;
    npix_d       = npix_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        pixel_d = '0;
        bit_d   = '0;
        ns_d    = '0;
        if (start) begin
          npix_d  = npix;
          state_d = start_state;
        end
      end

      StData: begin
        if (abort) begin
          pixel_d = '0;
          bit_d   = '0;
          ns_d    = '0;
          state_d = StLatch;
        end else if (slot_end) begin
          ns_d = '0;
          if (bit_end) begin
            bit_d = '0;
            if (pixel_end) begin
              pixel_d = '0;
              state_d = StLatch;
            end else begin
              pixel_d = pixel_q + PixelOne;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          ns_d = ns_q + NS_W'(1);
        end
      end

      StLatch: begin
        if (slot_end) begin
          ns_d = '0;
          if (latch_end) begin
            pixel_d      = '0;
            bit_d        = '0;
            frame_done_d = 1'b1;
            if (next_frame) begin
              npix_d  = npix;
              state_d = start_state;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          ns_d = ns_q + NS_W'(1);
        end
      end

      default: begin
        pixel_d = '0;
        bit_d   = '0;
        ns_d    = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pixel_q      <= '0;
      bit_q        <= '0;
      ns_q         <= '0;
      npix_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      bit_q        <= bit_d;
      ns_q         <= ns_d;
      npix_q       <= npix_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs decoded from state so an async reset clears them immediately.
  always_comb begin
    pixel      = pixel_q;
    bit_idx    = bit_q;
    ns         = ns_q;
    bit_start  = (state_q == StData) && (ns_q == '0);
    pixel_req  = bit_start && (bit_q == '0);
    latch      = (state_q == StLatch);
    busy       = (state_q != StIdle);
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_ws_frame_timer.sv
// Self-checking bench for ws_frame_timer: directed frame scenarios plus
// randomized stimulus against a phase/elapsed-time reference model.
module tb_ws_frame_timer;

  localparam int unsigned PIXEL_W     = 8;
  localparam int unsigned BIT_W       = 5;
  localparam int unsigned NS_W        = 8;
  localparam int unsigned BITS        = 3;
  localparam int unsigned NSS         = 4;
  localparam int unsigned LATCH_SLOTS = 2;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               continuous;
  logic               abort;
  logic [PIXEL_W-1:0] npix;
  logic [PIXEL_W-1:0] pixel;
  logic [BIT_W-1:0]   bit_idx;
  logic [NS_W-1:0]    ns;
  logic               bit_start;
  logic               pixel_req;
  logic               latch;
  logic               busy;
  logic               frame_done;

  int unsigned n_checks;
  int unsigned n_pass;

  // Reference model: phase (0 idle, 1 data, 2 latch) and elapsed cycles in it.
  int unsigned m_phase;
  int unsigned m_t;
  int unsigned m_npix;
  int unsigned m_done;

  ws_frame_timer #(
    .PIXEL_W    (PIXEL_W),
    .BIT_W      (BIT_W),
    .NS_W       (NS_W),
    .BITS       (BITS),
    .NSS        (NSS),
    .LATCH_SLOTS(LATCH_SLOTS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .continuous(continuous),
    .abort     (abort),
    .npix      (npix),
    .pixel     (pixel),
    .bit_idx   (bit_idx),
    .ns        (ns),
    .bit_start (bit_start),
    .pixel_req (pixel_req),
    .latch     (latch),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_t     = 0;
    m_npix  = 0;
    m_done  = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic model_step();
    int unsigned data_len;
    int unsigned latch_len;
    data_len  = m_npix * BITS * NSS;
    latch_len = LATCH_SLOTS * NSS;
    m_done    = 0;
    case (m_phase)
      0: begin
        if (start) begin
          m_npix  = npix;
          m_t     = 0;
          m_phase = (npix == 0) ? 2 : 1;
        end
      end
      1: begin
        if (abort || m_t == data_len - 1) begin
          m_phase = 2;
          m_t     = 0;
        end else begin
          m_t++;
        end
      end
      default: begin
        if (m_t == latch_len - 1) begin
          m_done = 1;
          m_t    = 0;
          if (continuous || start) begin
            m_npix  = npix;
            m_phase = (npix == 0) ? 2 : 1;
          end else begin
            m_phase = 0;
          end
        end else begin
          m_t++;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    int unsigned e_pix, e_bit, e_ns;
    e_pix = 0;
    e_bit = 0;
    e_ns  = 0;
    if (m_phase == 1) begin
      e_pix = m_t / (BITS * NSS);
      e_bit = (m_t / NSS) % BITS;
      e_ns  = m_t % NSS;
    end else if (m_phase == 2) begin
      e_bit = m_t / NSS;
      e_ns  = m_t % NSS;
    end
    check("pixel", 32'(pixel), e_pix);
    check("bit", 32'(bit_idx), e_bit);
    check("ns", 32'(ns), e_ns);
    check("bit_start", 32'(bit_start), 32'((m_phase == 1) && (e_ns == 0)));
    check("pixel_req", 32'(pixel_req), 32'((m_phase == 1) && (e_ns == 0) && (e_bit == 0)));
    check("latch", 32'(latch), 32'(m_phase == 2));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("frame_done", 32'(frame_done), m_done);
  endtask

  // Called just after a falling edge with inputs set; ends after the next one.
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int fd_idx;
    int first_latch;
    int n_latch;
    int n_bs;
    int n_data2;
    int req_q[$];
    logic fd_busy;
    logic fd_req;

    n_checks   = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    abort      = 1'b0;
    npix       = '0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle();

    // Single frame, npix=2.
    start = 1'b1;
    npix  = 8'd2;
    run_cycle();
    start = 1'b0;
    fd_idx = -1; n_latch = 0; fd_busy = 1'b1; req_q.delete();
    for (int n = 0; n < 40; n++) begin
      if (pixel_req) req_q.push_back(n);
      if (latch) n_latch++;
      if (frame_done) begin fd_idx = n; fd_busy = busy; end
      run_cycle();
    end
    check("single_req_count", req_q.size(), 2);
    if (req_q.size() == 2) begin
      check("single_req0", req_q[0], 0);
      check("single_req1", req_q[1], 12);
    end
    check("single_latch_len", n_latch, 8);
    check("single_done_idx", fd_idx, 32);
    check("single_done_busy", 32'(fd_busy), 0);

    // Zero-pixel frame.
    start = 1'b1;
    npix  = 8'd0;
    run_cycle();
    start = 1'b0;
    fd_idx = -1; n_latch = 0; n_bs = 0; first_latch = -1;
    for (int n = 0; n < 12; n++) begin
      if (latch) begin n_latch++; if (first_latch < 0) first_latch = n; end
      if (bit_start) n_bs++;
      if (frame_done) fd_idx = n;
      run_cycle();
    end
    check("zero_first_latch", first_latch, 0);
    check("zero_latch_len", n_latch, 8);
    check("zero_bit_start", n_bs, 0);
    check("zero_done_idx", fd_idx, 8);

    // Continuous mode, npix changed 1 -> 2 during frame 1.
    continuous = 1'b1;
    start      = 1'b1;
    npix       = 8'd1;
    run_cycle();
    start = 1'b0;
    fd_idx = -1; fd_req = 1'b0; n_data2 = 0;
    for (int n = 0; n < 60; n++) begin
      if (n == 3) npix = 8'd2;
      if (n == 21) continuous = 1'b0;
      if (frame_done && fd_idx < 0) begin fd_idx = n; fd_req = pixel_req; end
      if (n >= 20 && busy && !latch) n_data2++;
      run_cycle();
    end
    check("cont_done_idx", fd_idx, 20);
    check("cont_done_req", 32'(fd_req), 1);
    check("cont_frame2_data", n_data2, 24);

    // Abort at cycle 5, second abort during latch.
    start = 1'b1;
    npix  = 8'd2;
    run_cycle();
    start = 1'b0;
    fd_idx = -1; n_latch = 0; first_latch = -1;
    for (int n = 0; n < 20; n++) begin
      abort = (n == 4) || (n == 8);
      if (latch) begin n_latch++; if (first_latch < 0) first_latch = n; end
      if (frame_done) fd_idx = n;
      run_cycle();
    end
    abort = 1'b0;
    check("abort_first_latch", first_latch, 5);
    check("abort_latch_len", n_latch, 8);
    check("abort_done_idx", fd_idx, 13);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(7) == 0);
      abort = ($urandom_range(39) == 0);
      if ($urandom_range(199) == 0) continuous = ~continuous;
      if ($urandom_range(49) == 0) npix = 8'($urandom_range(255));
      else npix = 8'($urandom_range(3));
      run_cycle();
    end
    continuous = 1'b0;
    abort      = 1'b0;

    // Async reset in the middle of a data phase, between clock edges.
    start = 1'b1;
    npix  = 8'd3;
    run_cycle();
    start = 1'b0;
    for (int n = 0; n < 6; n++) run_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_latch", 32'(latch), 0);
    check("rst_bit_start", 32'(bit_start), 0);
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    run_cycle();
    start = 1'b1;
    npix  = 8'd1;
    run_cycle();
    start = 1'b0;
    check("post_rst_req", 32'(pixel_req), 1);
    for (int n = 0; n < 30; n++) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ws_frame_timer.md
# ws_frame_timer

Frame-level bit timer for WS2812-class serial LED strips. It generates nested slot/bit/pixel counters for a runtime-selectable pixel count, then holds a parametrised latch (reset) gap. It adds a start/busy/done handshake, a continuous-refresh mode and an abort. It sits between the frame buffer reader, which consumes `PIXEL_REQ`/`PIXEL`, and the waveform encoder, which consumes `NS`/`BIT`/`BIT_START`/`LATCH`.

## Interface
- `PIXEL_W`, 8: width of the `PIXEL` counter and of `NPIX`.
- `BIT_W`, 5: width of `BIT`. Must hold max(`BITS`, `LATCH_SLOTS`)-1.
- `NS_W`, 8: width of `NS`. Must hold `NSS`-1.
- `BITS`, 24: bits per pixel. Must be ≥1.
- `NSS`, 64: clock cycles per bit slot. Must be ≥2.
- `LATCH_SLOTS`, 16: length of the latch gap, in `NSS`-cycle slots. Must be ≥1.
- `CLK` in 1: the single clock. All logic is on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `START` in 1: frame request. Sampled in IDLE and at latch end.
- `CONTINUOUS` in 1: when high, a new frame starts automatically after each latch gap.
- `ABORT` in 1: cuts the data phase short and forces the latch gap.
- `NPIX` in `PIXEL_W`: pixel count. Captured at frame start. 0 means a latch-only frame.
- `PIXEL` out `PIXEL_W`: current pixel index.
- `BIT` out `BIT_W`: bit index in DATA, latch slot index in LATCH.
- `NS` out `NS_W`: cycle within the current slot.
- `BIT_START` out 1: combinational; equals (state==DATA && `NS`==0).
- `PIXEL_REQ` out 1: combinational; equals `BIT_START` && `BIT`==0.
- `LATCH` out 1: combinational; equals (state==LATCH).
- `BUSY` out 1: combinational; equals (state!=IDLE).
- `FRAME_DONE` out 1: registered one-cycle pulse marking the end of each frame.

## Operation
- States: IDLE, DATA, LATCH.
- Reset (`RST_N`=0, asynchronous):
  - state=IDLE.
  - `PIXEL`=`BIT`=`NS`=0, `FRAME_DONE`=0, internal `npix_q`=0.
  - All combinational outputs therefore read 0.
- IDLE:
  - Counters hold at 0.
  - `START`=1 → capture `npix_q`=`NPIX`, zero the counters, and go to DATA (or to LATCH if `NPIX`==0).
- DATA:
  - `NS` increments each cycle.
  - At `NS`==`NSS`-1: `NS`←0 and `BIT` increments.
  - At `BIT`==`BITS`-1 (with `NS` at `NSS`-1): `BIT`←0.
    - If `PIXEL`==`npix_q`-1: `PIXEL`←0 and go to LATCH.
    - Otherwise: `PIXEL`←`PIXEL`+1.
- LATCH:
  - `NS` counts 0..`NSS`-1 and `BIT` counts slots 0..`LATCH_SLOTS`-1.
  - At the last cycle (`BIT`==`LATCH_SLOTS`-1, `NS`==`NSS`-1): counters←0 and `FRAME_DONE`←1 for the next cycle.
  - Then, if `CONTINUOUS` or `START`: capture `NPIX` and go to DATA, or directly to LATCH again if `NPIX`==0.
  - Otherwise go to IDLE.
- `START` is ignored in DATA and in LATCH except at the last latch cycle. It is never queued.
- `ABORT`:
  - In DATA: counters←0 and go to LATCH, so a full latch gap follows.
  - Ignored in IDLE and in LATCH. In IDLE, `START` with `ABORT` is accepted.
- `NPIX` changes mid-frame have no effect. Only `npix_q` is used.
- Counter compares use equality on zero-extended values. No counter ever exceeds its limit, so there is no wrap past the limit.

## Timing
- `START` is sampled high at edge k → from edge k: `BUSY`=1, `NS`=0, `BIT_START`=`PIXEL_REQ`=1.
- Frame length in DATA: `npix_q`×`BITS`×`NSS` cycles.
- Latch length: `LATCH_SLOTS`×`NSS` cycles.
- `FRAME_DONE` is high for exactly the cycle after the last latch cycle.
  - In that cycle `BUSY`=0 if the block returns to IDLE.
  - In continuous mode that cycle is the first DATA cycle, with `PIXEL_REQ`=1. There is no idle gap between frames.
- `ABORT` high at edge j in DATA → `LATCH`=1 and `NS`=`BIT`=0 from edge j.
- Reset asserted mid-frame → outputs are 0 immediately, without waiting for a clock edge.

## Test plan
Parameters `NSS`=4, `BITS`=3, `LATCH_SLOTS`=2 unless noted.

- **Single frame:** `NPIX`=2, `START` pulsed at edge 0 → `PIXEL_REQ` at cycles 0 and 12; DATA for 24 cycles; `LATCH`=1 for cycles 24-31; `FRAME_DONE`=1 only at cycle 32, with `BUSY`=0.
- **Zero pixels:** `NPIX`=0, `START` → `LATCH`=1 immediately for 8 cycles; no `BIT_START`; `FRAME_DONE` at cycle 8.
- **Continuous mode:** `CONTINUOUS`=1, `NPIX`=1 changed to 2 during frame 1 → frame 1 is 12+8 cycles; at cycle 20 both `FRAME_DONE`=1 and `PIXEL_REQ`=1; frame 2 has 24 DATA cycles.
- **Abort:** `ABORT` at cycle 5 of an `NPIX`=2 frame → `LATCH` from cycle 5, lasting 8 cycles; `FRAME_DONE` at cycle 13. A second `ABORT` during LATCH is ignored.
- **Async reset:** `RST_N` dropped mid-DATA between clock edges → all outputs 0 without a clock edge; after release, `START` begins a clean frame.
- **Wide parameters:** `PIXEL_W`=8, `NPIX`=255, `BITS`=24, `NSS`=64 → last `PIXEL` value is 254; DATA lasts 391680 cycles; no counter overflow.
